mem_responder: RTL and testbench

- Memory-side responder for the CPU memory handshake: EN (request), RW (1 = read, 0 = write) and MFC (memory function complete).
- Presents the addressed word to the MDR on reads and stores MDR data on writes.
- Inserts a programmable number of wait states before it raises MFC.
- Sits between the MAR/MDR datapath and a synchronous single-port storage array. It is the slave end of the four-phase handshake driven by the fetch and execute controllers.

---
 rtl/mem_if_pkg.sv | 18 +
 rtl/mem_array_sp.sv | 31 +++
 rtl/mem_responder.sv | 164 ++++++++++++++++
 tb/tb_mem_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the CPU memory handshake: responder states,
// read/write encoding and the default datapath widths.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } resp_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

endpackage

// File: rtl/mem_array_sp.sv
// Synchronous single-port storage array. The read port is registered, so
// dout reflects the word addressed at the previous rising edge. The
// contents are deliberately not reset.
module mem_array_sp #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] dout_r;

    // Write port and registered read port (read-before-write on a collision).
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end else begin
            mem_r[addr] <= mem_r[addr];
        end
        dout_r <= mem_r[addr];
    end

    assign dout = dout_r;

endmodule

// File: rtl/mem_responder.sv
// Memory-side slave of the four-phase EN/MFC handshake. A request is
// latched on acceptance, held through a programmable number of wait
// states, performed in ACCESS, and then MFC is held until EN drops.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN,
    input  logic              RW,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              MFC,
    output logic              busy,
    output logic              addr_err
);

    // Array index width; DEPTH never exceeds 2**ADDR_W so this fits in addr.
    localparam int              MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_V  = 4'(WAIT_CYCLES);

    resp_state_t       state_r,   state_nxt_s;
    logic [3:0]        cnt_r,     cnt_nxt_s;
    logic [ADDR_W-1:0] addr_l_r,  addr_l_nxt_s;
    logic              rw_l_r,    rw_l_nxt_s;
    logic [DATA_W-1:0] wdata_l_r, wdata_l_nxt_s;
    logic [DATA_W-1:0] rdata_r,   rdata_nxt_s;
    logic              mfc_r,     mfc_nxt_s;
    logic              err_r,     err_nxt_s;
    logic              busy_r,    busy_nxt_s;

    logic              addr_bad_s;
    logic              mem_we_s;
    logic [MEM_AW-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_dout_s;

    // Compare one bit wider so DEPTH == 2**ADDR_W is representable.
    assign addr_bad_s = ({1'b0, addr_l_r} >= DEPTH_V);

    // While idle the array is fed the live address so that the word is
    // already in dout when ACCESS is reached, even with zero wait states.
    assign mem_addr_s = (state_r == IDLE) ? addr[MEM_AW-1:0] : addr_l_r[MEM_AW-1:0];

    mem_array_sp #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (MEM_AW)
    ) u_array (
        .clk  (clk),
        .we   (mem_we_s),
        .addr (mem_addr_s),
        .din  (wdata_l_r),
        .dout (mem_dout_s)
    );

    // Next-state, request latches, access strobe and output values.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        addr_l_nxt_s  = addr_l_r;
        rw_l_nxt_s    = rw_l_r;
        wdata_l_nxt_s = wdata_l_r;
        rdata_nxt_s   = rdata_r;
        mfc_nxt_s     = mfc_r;
        err_nxt_s     = err_r;
        mem_we_s      = 1'b0;

        case (state_r)
            IDLE: begin
                if (EN) begin
                    addr_l_nxt_s  = addr;
                    rw_l_nxt_s    = RW;
                    wdata_l_nxt_s = wdata;
                    cnt_nxt_s     = WAIT_V;
                    state_nxt_s   = (WAIT_V == 4'd0) ? ACCESS : WAIT;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            WAIT: begin
                if (!EN) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r <= 4'd1) begin
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = ACCESS;
                end else begin
                    cnt_nxt_s   = cnt_r - 4'd1;
                end
            end
            ACCESS: begin
                if (!EN) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                    mfc_nxt_s   = 1'b1;
                    if (addr_bad_s) begin
                        err_nxt_s   = 1'b1;
                        rdata_nxt_s = '0;
                    end else if (rw_l_r == RW_READ) begin
                        err_nxt_s   = 1'b0;
                        rdata_nxt_s = mem_dout_s;
                    end else begin
                        err_nxt_s   = 1'b0;
                        mem_we_s    = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!EN) begin
                    state_nxt_s = IDLE;
                    mfc_nxt_s   = 1'b0;
                    err_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                mfc_nxt_s   = 1'b0;
                err_nxt_s   = 1'b0;
            end
        endcase

        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // State, latches and registered outputs; reset drops MFC at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            addr_l_r  <= '0;
            rw_l_r    <= 1'b0;
            wdata_l_r <= '0;
            rdata_r   <= '0;
            mfc_r     <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            addr_l_r  <= addr_l_nxt_s;
            rw_l_r    <= rw_l_nxt_s;
            wdata_l_r <= wdata_l_nxt_s;
            rdata_r   <= rdata_nxt_s;
            mfc_r     <= mfc_nxt_s;
            err_r     <= err_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    assign rdata    = rdata_r;
    assign MFC      = mfc_r;
    assign busy     = busy_r;
    assign addr_err = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and
// a 128-word array (address error range), one with zero wait states.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rw;
    logic        sel;
    logic [7:0]  addr;
    logic [15:0] wdata;

    logic        en2, en0;
    logic [15:0] rdata2, rdata0, rdata_m;
    logic        mfc2, mfc0, mfc_m;
    logic        busy2, busy0, busy_m;
    logic        err2, err0, err_m;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign en2     = en & ~sel;
    assign en0     = en & sel;
    assign rdata_m = sel ? rdata0 : rdata2;
    assign mfc_m   = sel ? mfc0   : mfc2;
    assign busy_m  = sel ? busy0  : busy2;
    assign err_m   = sel ? err0   : err2;

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(128), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .EN(en2), .RW(rw), .addr(addr), .wdata(wdata),
        .rdata(rdata2), .MFC(mfc2), .busy(busy2), .addr_err(err2)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .EN(en0), .RW(rw), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .MFC(mfc0), .busy(busy0), .addr_err(err0)
    );

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk16(name, {15'd0, act}, {15'd0, exp});
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a falling edge: raise EN and wait (bounded) for MFC,
    // scrambling the request inputs once the request has been accepted.
    task automatic run_txn(input logic rw_i, input logic [7:0] a, input logic [15:0] d,
                           output int lat, output logic [15:0] rd, output logic er);
        en    = 1'b1;
        rw    = rw_i;
        addr  = a;
        wdata = d;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
            rw    = ~rw_i;
            addr  = ~a;
            wdata = ~d;
        end while (!mfc_m && lat < 40);
        rd = rdata_m;
        er = err_m;
    endtask

    // Drop EN at a falling edge; MFC and busy must be low one edge later.
    task automatic release_en(input string tag);
        en = 1'b0;
        @(negedge clk);
        chk1({tag, " mfc_drop"}, mfc_m, 1'b0);
        chk1({tag, " busy_drop"}, busy_m, 1'b0);
    endtask

    typedef struct {
        logic        rw;
        logic [7:0]  a;
        logic [15:0] d;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int          lat;
        logic [15:0] rd;
        logic        er;

        // rw, addr, wdata, expected rdata after MFC, expected addr_err
        tbl[0]  = '{1'b0, 8'h10, 16'hBEEF, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 8'h10, 16'h0000, 16'hBEEF, 1'b0};
        tbl[2]  = '{1'b0, 8'h20, 16'hAAAA, 16'hBEEF, 1'b0};
        tbl[3]  = '{1'b0, 8'h40, 16'h4040, 16'hBEEF, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 16'h0A0A, 16'hBEEF, 1'b0};
        tbl[5]  = '{1'b0, 8'h7F, 16'h1357, 16'hBEEF, 1'b0};
        tbl[6]  = '{1'b1, 8'h7F, 16'h0000, 16'h1357, 1'b0};
        tbl[7]  = '{1'b0, 8'hC0, 16'h5555, 16'h0000, 1'b1};
        tbl[8]  = '{1'b1, 8'h40, 16'h0000, 16'h4040, 1'b0};
        tbl[9]  = '{1'b0, 8'h80, 16'h9999, 16'h0000, 1'b1};
        tbl[10] = '{1'b1, 8'h00, 16'h0000, 16'h0A0A, 1'b0};
        tbl[11] = '{1'b1, 8'hC0, 16'h0000, 16'h0000, 1'b1};
        tbl[12] = '{1'b1, 8'h80, 16'h0000, 16'h0000, 1'b1};
        tbl[13] = '{1'b1, 8'h10, 16'h0000, 16'hBEEF, 1'b0};

        rst   = 1'b0;
        en    = 1'b0;
        rw    = 1'b0;
        sel   = 1'b0;
        addr  = 8'h00;
        wdata = 16'h0000;
        repeat (2) @(negedge clk);
        chk1("reset mfc", mfc2, 1'b0);
        chk1("reset busy", busy2, 1'b0);
        chk1("reset addr_err", err2, 1'b0);
        chk16("reset rdata", rdata2, 16'h0000);
        chk16("reset rdata w0", rdata0, 16'h0000);
        rst = 1'b1;
        @(negedge clk);

        // Table of back-to-back transactions, two wait states, DEPTH = 128.
        for (int i = 0; i < 14; i++) begin
            run_txn(tbl[i].rw, tbl[i].a, tbl[i].d, lat, rd, er);
            chk_int($sformatf("vec%0d latency", i), lat, 4);
            chk16($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
            chk1($sformatf("vec%0d addr_err", i), er, tbl[i].exp_err);
            release_en($sformatf("vec%0d", i));
        end

        // Hold a read: MFC and rdata stay put while EN remains high.
        run_txn(1'b1, 8'h7F, 16'h0000, lat, rd, er);
        chk16("hold_rd rdata", rd, 16'h1357);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1($sformatf("hold_rd mfc %0d", i), mfc_m, 1'b1);
            chk16($sformatf("hold_rd rdata %0d", i), rdata_m, 16'h1357);
        end
        release_en("hold_rd");

        // Hold a write while the data inputs wander; only the latched word lands.
        run_txn(1'b0, 8'h10, 16'h1111, lat, rd, er);
        chk_int("hold_wr latency", lat, 4);
        for (int i = 0; i < 10; i++) begin
            wdata = 16'(i * 16'h0101);
            @(negedge clk);
            chk1($sformatf("hold_wr mfc %0d", i), mfc_m, 1'b1);
            chk16($sformatf("hold_wr rdata %0d", i), rdata_m, 16'h1357);
        end
        release_en("hold_wr");
        run_txn(1'b1, 8'h10, 16'h0000, lat, rd, er);
        chk16("hold_wr readback", rd, 16'h1111);
        release_en("hold_wr rb");

        // Abort during WAIT: no MFC, no write.
        en = 1'b1; rw = 1'b0; addr = 8'h20; wdata = 16'h1234;
        @(negedge clk);
        chk1("abort_wait busy", busy_m, 1'b1);
        chk1("abort_wait mfc", mfc_m, 1'b0);
        en = 1'b0;
        @(negedge clk);
        chk1("abort_wait idle", busy_m, 1'b0);
        @(negedge clk);
        chk1("abort_wait mfc late", mfc_m, 1'b0);

        // Abort with EN low at the ACCESS edge: no write either.
        en = 1'b1; rw = 1'b0; addr = 8'h20; wdata = 16'h2222;
        repeat (3) begin
            @(negedge clk);
            chk1("abort_acc mfc", mfc_m, 1'b0);
        end
        release_en("abort_acc");
        run_txn(1'b1, 8'h20, 16'h0000, lat, rd, er);
        chk16("abort readback", rd, 16'hAAAA);
        release_en("abort rb");

        // Reset during WAIT of a write, then during DONE of a read.
        run_txn(1'b0, 8'h30, 16'h3030, lat, rd, er);
        release_en("pre_rst wr");
        run_txn(1'b1, 8'h30, 16'h0000, lat, rd, er);
        chk16("pre_rst rdata", rd, 16'h3030);
        release_en("pre_rst rd");
        en = 1'b1; rw = 1'b0; addr = 8'h30; wdata = 16'h6060;
        @(negedge clk);
        chk1("rst_wait busy before", busy_m, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk1("rst_wait mfc", mfc_m, 1'b0);
        chk1("rst_wait busy", busy_m, 1'b0);
        chk16("rst_wait rdata", rdata_m, 16'h0000);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_txn(1'b1, 8'h30, 16'h0000, lat, rd, er);
        chk_int("post_rst latency", lat, 4);
        chk16("post_rst rdata", rd, 16'h3030);
        #2 rst = 1'b0;
        #1;
        chk1("rst_done mfc", mfc_m, 1'b0);
        chk16("rst_done rdata", rdata_m, 16'h0000);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Zero wait states: busy exactly one cycle ahead of MFC.
        sel = 1'b1;
        run_txn(1'b0, 8'h05, 16'h0505, lat, rd, er);
        chk_int("w0 write latency", lat, 2);
        release_en("w0 write");
        en = 1'b1; rw = 1'b1; addr = 8'h05; wdata = 16'h0000;
        @(negedge clk);
        chk1("w0 busy early", busy_m, 1'b1);
        chk1("w0 mfc early", mfc_m, 1'b0);
        addr = 8'hFF;
        @(negedge clk);
        chk1("w0 mfc", mfc_m, 1'b1);
        chk16("w0 rdata", rdata_m, 16'h0505);
        chk1("w0 addr_err", err_m, 1'b0);
        release_en("w0 read");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
